// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit accumulator multicycle datapath: sequences
// fetch, decode, memory access, ALU execute and write-back, and drives every strobe/select.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Op,
  input  logic [8:0] Func,
  input  logic       Zero,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       A3Src,
  output logic       PCWrite,
  output logic       OldPCWrite,
  output logic       MDRWrite,
  output logic       ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMRD, S_MEMWB, S_MEMWR, S_JUMP,
    S_BRZ, S_EXEC_R, S_EXEC_I, S_ALUWB, S_HALT
  } state_t;

  state_t state_q, state_d;

  // Op/Func come from IR, which only changes in FETCH, so they stay valid through write-back.
  logic rtype_ok;
  logic is_moveto;
  assign rtype_ok  = (Func[8:7] == 2'b00) && $onehot(Func[6:0]);
  assign is_moveto = (Op == 4'b1000) && (Func == 9'h001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          4'b0000: state_d = S_MEMRD;
          4'b0001: state_d = S_MEMWR;
          4'b0010: state_d = S_JUMP;
          4'b0011: state_d = S_HALT;
          4'b0100: state_d = S_BRZ;
          4'b1000: state_d = rtype_ok ? S_EXEC_R : S_FETCH;
          4'b1100, 4'b1101, 4'b1110, 4'b1111: state_d = S_EXEC_I;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_BRZ:    state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    A3Src      = 1'b0;
    PCWrite    = 1'b0;
    OldPCWrite = 1'b0;
    MDRWrite   = 1'b0;
    ResultSrc  = 1'b0;
    halted     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        PCWrite    = 1'b1;
        IRWrite    = 1'b1;
        OldPCWrite = 1'b1;
      end
      S_MEMRD: begin
        AdrSrc   = 1'b1;
        MDRWrite = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b01;
        PCWrite = 1'b1;
      end
      S_BRZ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b101;
        PCSrc      = 2'b10;
        PCWrite    = Zero;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        case (Func)
          9'h001:  ALUControl = 3'b101;
          9'h002:  ALUControl = 3'b110;
          9'h004:  ALUControl = 3'b000;
          9'h008:  ALUControl = 3'b001;
          9'h010:  ALUControl = 3'b010;
          9'h020:  ALUControl = 3'b011;
          9'h040:  ALUControl = 3'b100;
          default: ALUControl = 3'b000;
        endcase
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b10;
        ALUControl = {1'b0, Op[1:0]};
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        A3Src    = is_moveto;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset suppresses every strobe immediately so an aborted instruction writes nothing.
    if (!reset) begin
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      A3Src      = 1'b0;
      PCWrite    = 1'b0;
      OldPCWrite = 1'b0;
      MDRWrite   = 1'b0;
      ResultSrc  = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the 16-bit accumulator-based multicycle datapath: fetch, decode, memory access, ALU execute and register write-back. It consumes `Op`, `Func` and `Zero` from the datapath and drives every datapath control strobe and mux select, plus a `halted` status flag.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `Op`  in  4  `Instr[15:12]`
- `Func`  in  9  `Instr[8:0]`, one-hot for Op=1000
- `Zero`  in  1  ALU zero flag, combinational, same cycle
- `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite`, `A3Src`, `PCWrite`, `OldPCWrite`, `MDRWrite`, `ResultSrc`  out  1 each  datapath strobes/selects
- `ALUSrcA`, `ALUSrcB`, `ImmSrc`, `PCSrc`  out  2 each  mux selects
- `ALUControl`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT In2, 101 PASS In1, 110 PASS In2
- `halted`  out  1  high in HALT

## Operation
- Default for every output in every state is 0; only the listed signals are driven.
- R0 is the accumulator (A = R0); B = R[Instr[11:9]].
- FETCH: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD, PCSrc=00, PCWrite=1, IRWrite=1, OldPCWrite=1 -> DECODE.
- DECODE: no strobes; A/B load from the register file. Next state by Op:
  - 0000 LOAD -> MEMRD
  - 0001 STORE -> MEMWR
  - 0010 JUMP -> JUMP
  - 0011 HLT -> HALT
  - 0100 BRZ -> BRZ
  - 1000 R-type -> EXEC_R; Func=9'h080 (NOP) -> FETCH
  - 11xx I-type -> EXEC_I
  - other Op, or R-type Func not exactly one of bits [7:0] -> FETCH, no side effects.
- MEMRD: AdrSrc=1, MDRWrite=1 -> MEMWB.
- MEMWB: RegWrite=1, ResultSrc=1, A3Src=0 (R0 <- Mem) -> FETCH.
- MEMWR: AdrSrc=1, MemWrite=1 (Mem[Instr[11:0]] <- R0) -> FETCH.
- JUMP: PCSrc=01, PCWrite=1 -> FETCH.
- BRZ: ALUSrcA=10, ALUControl=PASS In1, PCSrc=10, PCWrite=Zero (branch when R0==0) -> FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00. ALUControl by Func: bit0 MOVETO=PASS In1; bit1 MOVEFROM=PASS In2; bit2 ADD; bit3 SUB; bit4 AND; bit5 OR; bit6 NOT -> ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ImmSrc=00. ALUControl: Op 1100 ADD, 1101 SUB, 1110 AND, 1111 OR -> ALUWB.
- ALUWB: RegWrite=1, ResultSrc=0. A3Src=1 only when the latched instruction is R-type MOVETO (Ri <- R0), else 0 (R0 <- ALUOut) -> FETCH.
- HALT: `halted`=1, no strobes. The FSM stays in HALT until reset.

## Timing
- Cycles per instruction: NOP/illegal 2; STORE, JUMP, BRZ 3; LOAD, R-type, I-type 4.
- Next-state and outputs use the `Op`/`Func` values held in IR. IR is only written in FETCH, so these inputs are stable from DECODE onward.
- PC+1 is written at the FETCH edge. OldPC captures the pre-increment PC on the same edge.
- `Zero` is sampled combinationally in BRZ. The PC update takes effect on that state's edge.
- Reset: state <- FETCH immediately. While `reset`=0, all 1-bit strobes are forced to 0, regardless of state.
- FETCH strobes begin on the first rising edge window after reset deasserts.
- Reset mid-instruction aborts it. No partial write completes after `reset` falls.

## Test plan
- Reset held 3 cycles, then released: all strobes 0 during reset. First cycle after release shows FETCH (PCWrite=IRWrite=OldPCWrite=1), then DECODE.
- LOAD 0x005 (Instr 16'h0005): 4-cycle sequence FETCH, DECODE, MEMRD (AdrSrc=1, MDRWrite=1), MEMWB (RegWrite=1, ResultSrc=1, A3Src=0).
- BRZ twice: with Zero=1, BRZ cycle shows PCWrite=1, PCSrc=10. Repeat with Zero=0: PCWrite=0. Next cycle is FETCH in both cases.
- R-type Func=9'h001 (MOVETO): ALUWB has A3Src=1, RegWrite=1. Func=9'h008 (SUB): EXEC_R ALUControl=001, ALUWB A3Src=0. Func=9'h003 (invalid): DECODE -> FETCH, no RegWrite.
- I-type Op=1110: EXEC_I shows ALUSrcB=10, ImmSrc=00, ALUControl=010, then ALUWB.
- HLT (Op=0011): `halted`=1 for 20 cycles with no strobes. Pulsing reset low returns the FSM to FETCH with `halted`=0.
